pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: HANG_LIMIT, default 1024, consecutive stalled cycles before hang_o asserts.
REQ-002 clock  in  1  single clock; all state updates on posedge clock.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 stallreq_if  in  1  IF stage fetch not complete.
REQ-005 stallreq_id  in  1  ID stage load-use hazard.
REQ-006 stallreq_ex  in  1  EX stage multi-cycle op busy.
REQ-007 stallreq_mem  in  1  MEM stage memory access busy.
REQ-008 branch_taken_i  in  1  EX resolved taken branch or jump this cycle.
REQ-009 branch_target_i  in  32  redirect address paired with branch_taken_i.
REQ-010 stall  out  6  StallBus: bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-011 flush_o  out  1  forces IF/ID register to bubble.
REQ-012 pc_redirect_o  out  1  one-cycle PC load strobe.
REQ-013 pc_target_o  out  32  PC load value, valid with pc_redirect_o.
REQ-014 hang_o  out  1  stall watchdog flag.

Function
REQ-015 stall SHALL be combinational from requests, highest stage wins: mem -> 011111; else ex -> 001111; else id -> 000111; else if -> 000011; else 000000.
REQ-016 stall SHALL always be a contiguous low-order mask; downstream register k holds when stall[k]&stall[k+1], bubbles when stall[k]&!stall[k+1].
REQ-017 Branch accepted only when branch_taken_i=1 and stall[3]=0; otherwise ignored (EX replays).
REQ-018 FSM states IDLE, BR_WAIT; IDLE on reset.
REQ-019 IDLE, branch accepted, stallreq_if=0: next cycle pc_redirect_o=1, flush_o=1, pc_target_o=branch_target_i; stay IDLE.
REQ-020 IDLE, branch accepted, stallreq_if=1: latch target; go BR_WAIT.
REQ-021 BR_WAIT: flush_o=1 every cycle; on first cycle with stallreq_if=0, next cycle pc_redirect_o=1 with latched target, flush_o=1, go IDLE.
REQ-022 Branch accepted while in BR_WAIT SHALL overwrite the latched target; state unchanged.
REQ-023 pc_redirect_o SHALL be high for exactly one cycle per redirect; pc_target_o holds last value otherwise.
REQ-024 Watchdog: 16-bit counter increments each cycle stall!=0, saturates at 0xFFFF, clears to 0 the cycle stall==0.
REQ-025 hang_o SHALL be registered, high while counter >= HANG_LIMIT.
REQ-026 flush_o and pc_redirect_o SHALL be registered outputs (one-cycle latency from acceptance).

Reset
REQ-027 On reset: state IDLE, flush_o=0, pc_redirect_o=0, pc_target_o=0, counter=0, hang_o=0; stall follows inputs combinationally.
REQ-028 Reset in BR_WAIT SHALL discard the latched target; no redirect issued afterward.

Structure
REQ-029 StallBus width (6), stall index constants, RegBus/AddrBus (32) SHALL come from the shared define file.
REQ-030 Watchdog SHALL be a sub-module stall_watchdog (counter, saturation, compare); FSM and priority mask stay in pipe_ctrl.

Verification
REQ-031 stallreq_id=1 and stallreq_if=1, others 0 -> stall=000111; add stallreq_mem=1 -> stall=011111.
REQ-032 IDLE, stallreq_if=0, branch_taken_i=1, target 0x00001000 -> next cycle pc_redirect_o=1, pc_target_o=0x00001000, flush_o=1; following cycle pc_redirect_o=0.
REQ-033 stallreq_if=1 for 3 cycles, branch at cycle 0 target 0x200 -> flush_o=1 cycles 1-3, pc_redirect_o=1 only in cycle after stallreq_if drops, target 0x200.
REQ-034 branch_taken_i=1 with stallreq_ex=1 -> no redirect, no flush, state IDLE.
REQ-035 HANG_LIMIT=4, stallreq_mem=1 held 6 cycles -> hang_o rises after 4 stalled cycles; stall released -> counter 0, hang_o=0 next cycle.
REQ-036 reset asserted one cycle in BR_WAIT (target 0x300) -> after reset no pc_redirect_o ever, flush_o=0, state IDLE.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: bus widths, stall bit
// indices, controller state encoding and the stall-mask helper.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W   = 6;
    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WDOG_W = 16;

    typedef logic [STALL_W-1:0] stall_bus_t;
    typedef logic [REG_W-1:0]   reg_bus_t;
    typedef logic [ADDR_W-1:0]  addr_bus_t;

    typedef enum logic {
        ST_IDLE,
        ST_BR_WAIT
    } ctrl_state_t;

    // Contiguous low-order mask with bits [top:0] set.
    function automatic stall_bus_t stall_fill(input int unsigned top);
        stall_bus_t m;
        m = '0;
        for (int unsigned i = 0; i < STALL_W; i++) begin
            m[i] = (i <= top);
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-to-controller bundle: per-stage stall requests and EX branch
// resolution in, stall bus / flush / PC redirect / hang flag out.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic       stallreq_if;
    logic       stallreq_id;
    logic       stallreq_ex;
    logic       stallreq_mem;
    logic       branch_taken_i;
    addr_bus_t  branch_target_i;

    stall_bus_t stall;
    logic       flush_o;
    logic       pc_redirect_o;
    addr_bus_t  pc_target_o;
    logic       hang_o;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
               branch_taken_i, branch_target_i,
        input  stall, flush_o, pc_redirect_o, pc_target_o, hang_o
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
               branch_taken_i, branch_target_i,
        output stall, flush_o, pc_redirect_o, pc_target_o, hang_o
    );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles (saturating) and raises a registered
// hang flag once the run reaches HANG_LIMIT.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned HANG_LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic stall_any,
    output logic hang_o
);

    logic [WDOG_W-1:0] count;
    logic [WDOG_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (!stall_any) begin
            count_nxt = '0;
        end else if (count != '1) begin
            count_nxt = count + WDOG_W'(1);
        end
    end

    // Compare against the next count so hang_o and the counter move together.
    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            hang_o <= 1'b0;
        end else begin
            count  <= count_nxt;
            hang_o <= (32'(count_nxt) >= HANG_LIMIT);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: priority stall mask, branch redirect FSM with
// fetch-wait handling, and stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned HANG_LIMIT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);

    stall_bus_t  stall_mask;
    logic        accept;
    ctrl_state_t state;
    addr_bus_t   pend_target;
    logic        flush_q;
    logic        redirect_q;
    addr_bus_t   target_q;
    logic        hang_q;

    // Highest requesting stage freezes itself and everything upstream.
    always_comb begin
        stall_mask = '0;
        if (bus.stallreq_mem) begin
            stall_mask = stall_fill(STALL_MEM);
        end else if (bus.stallreq_ex) begin
            stall_mask = stall_fill(STALL_EX);
        end else if (bus.stallreq_id) begin
            stall_mask = stall_fill(STALL_ID);
        end else if (bus.stallreq_if) begin
            stall_mask = stall_fill(STALL_IF);
        end
    end

    // A branch seen while EX is held will be replayed, so ignore it now.
    assign accept = bus.branch_taken_i & ~stall_mask[STALL_EX];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            pend_target <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            target_q    <= '0;
        end else begin
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        flush_q <= 1'b1;
                        if (!bus.stallreq_if) begin
                            redirect_q <= 1'b1;
                            target_q   <= bus.branch_target_i;
                        end else begin
                            pend_target <= bus.branch_target_i;
                            state       <= ST_BR_WAIT;
                        end
                    end
                end
                ST_BR_WAIT: begin
                    // Newest accepted branch supersedes the held target.
                    flush_q <= 1'b1;
                    if (!bus.stallreq_if) begin
                        redirect_q <= 1'b1;
                        target_q   <= accept ? bus.branch_target_i : pend_target;
                        state      <= ST_IDLE;
                    end else if (accept) begin
                        pend_target <= bus.branch_target_i;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    stall_watchdog #(
        .HANG_LIMIT(HANG_LIMIT)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .stall_any (|stall_mask),
        .hang_o    (hang_q)
    );

    assign bus.stall         = stall_mask;
    assign bus.flush_o       = flush_q;
    assign bus.pc_redirect_o = redirect_q;
    assign bus.pc_target_o   = target_q;
    assign bus.hang_o        = hang_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and random checks of pipe_ctrl against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int unsigned LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .HANG_LIMIT(LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_wait;
    logic [31:0] m_tgt;
    bit          e_redirect;
    bit          e_flush;
    logic [31:0] e_target;
    bit          e_hang;
    int unsigned m_run;

    function automatic logic [5:0] ref_stall();
        int unsigned depth;
        depth = 0;
        if (bus.stallreq_mem)      depth = 5;
        else if (bus.stallreq_ex)  depth = 4;
        else if (bus.stallreq_id)  depth = 3;
        else if (bus.stallreq_if)  depth = 2;
        return 6'((1 << depth) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("stall",    32'(bus.stall),         32'(ref_stall()));
        chk("flush",    32'(bus.flush_o),       32'(e_flush));
        chk("redirect", 32'(bus.pc_redirect_o), 32'(e_redirect));
        chk("target",   bus.pc_target_o,        e_target);
        chk("hang",     32'(bus.hang_o),        32'(e_hang));
    endtask

    task automatic drive(input bit s_if, input bit s_id, input bit s_ex, input bit s_mem,
                         input bit taken, input logic [31:0] target);
        bus.stallreq_if     = s_if;
        bus.stallreq_id     = s_id;
        bus.stallreq_ex     = s_ex;
        bus.stallreq_mem    = s_mem;
        bus.branch_taken_i  = taken;
        bus.branch_target_i = target;
    endtask

    // Advance one clock: model consumes the inputs present before the edge.
    task automatic cycle();
        logic [5:0]  s;
        bit          acc;
        logic [31:0] t;
        s   = ref_stall();
        acc = bus.branch_taken_i && !(bus.stallreq_ex || bus.stallreq_mem);
        if (reset) begin
            m_wait = 0; m_tgt = '0; e_redirect = 0; e_flush = 0;
            e_target = '0; e_hang = 0; m_run = 0;
        end else begin
            e_redirect = 0;
            e_flush    = 0;
            if (m_wait) begin
                e_flush = 1;
                t = acc ? bus.branch_target_i : m_tgt;
                if (!bus.stallreq_if) begin
                    e_redirect = 1; e_target = t; m_wait = 0;
                end else begin
                    m_tgt = t;
                end
            end else if (acc) begin
                e_flush = 1;
                if (!bus.stallreq_if) begin
                    e_redirect = 1; e_target = bus.branch_target_i;
                end else begin
                    m_tgt = bus.branch_target_i; m_wait = 1;
                end
            end
            m_run  = (s != 0) ? ((m_run < 65535) ? m_run + 1 : 65535) : 0;
            e_hang = (m_run >= LIMIT);
        end
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, '0);
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_flush",    32'(bus.flush_o),       32'd0);
        chk("rst_redirect", 32'(bus.pc_redirect_o), 32'd0);
        chk("rst_target",   bus.pc_target_o,        32'd0);
        chk("rst_hang",     32'(bus.hang_o),        32'd0);
        reset = 1'b0;

        // Stall priority
        drive(1, 1, 0, 0, 0, '0);
        #1 chk("stall_id_if", 32'(bus.stall), 32'b000111);
        bus.stallreq_mem = 1'b1;
        #1 chk("stall_mem", 32'(bus.stall), 32'b011111);
        bus.stallreq_mem = 1'b0; bus.stallreq_id = 1'b0;
        #1 chk("stall_if", 32'(bus.stall), 32'b000011);
        bus.stallreq_if = 1'b0; bus.stallreq_ex = 1'b1;
        #1 chk("stall_ex", 32'(bus.stall), 32'b001111);
        drive(0, 0, 0, 0, 0, '0);
        cycle();

        // Immediate redirect
        drive(0, 0, 0, 0, 1, 32'h0000_1000);
        cycle();
        chk("br_redirect", 32'(bus.pc_redirect_o), 32'd1);
        chk("br_target",   bus.pc_target_o,        32'h0000_1000);
        chk("br_flush",    32'(bus.flush_o),       32'd1);
        drive(0, 0, 0, 0, 0, '0);
        cycle();
        chk("br_pulse_end", 32'(bus.pc_redirect_o), 32'd0);

        // Redirect held while fetch is busy
        drive(1, 0, 0, 0, 1, 32'h0000_0200);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            bus.branch_taken_i = 1'b0;
            chk("wait_flush",    32'(bus.flush_o),       32'd1);
            chk("wait_redirect", 32'(bus.pc_redirect_o), 32'd0);
        end
        bus.stallreq_if = 1'b0;
        cycle();
        chk("wait_redirect_go", 32'(bus.pc_redirect_o), 32'd1);
        chk("wait_target",      bus.pc_target_o,        32'h0000_0200);
        chk("wait_flush_go",    32'(bus.flush_o),       32'd1);
        cycle();
        chk("wait_done_redir", 32'(bus.pc_redirect_o), 32'd0);
        chk("wait_done_flush", 32'(bus.flush_o),       32'd0);

        // Branch ignored while EX is stalled
        drive(0, 0, 1, 0, 1, 32'h0000_4444);
        cycle();
        chk("exstall_redirect", 32'(bus.pc_redirect_o), 32'd0);
        chk("exstall_flush",    32'(bus.flush_o),       32'd0);
        drive(0, 0, 0, 0, 0, '0);
        cycle();
        chk("exstall_idle",   32'(bus.flush_o),     32'd0);
        chk("exstall_target", bus.pc_target_o,      32'h0000_0200);

        // Watchdog
        cycle();
        drive(0, 0, 0, 1, 0, '0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("hang_run", 32'(bus.hang_o), (i >= 3) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 0, 0, 0, '0);
        cycle();
        chk("hang_clear", 32'(bus.hang_o), 32'd0);
        drive(0, 0, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) cycle();
        chk("hang_restart", 32'(bus.hang_o), 32'd0);

        // Reset discards a pending redirect
        drive(1, 0, 0, 0, 1, 32'h0000_0300);
        cycle();
        chk("rstwait_flush", 32'(bus.flush_o), 32'd1);
        drive(1, 0, 0, 0, 0, '0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rstwait_no_redir", 32'(bus.pc_redirect_o), 32'd0);
            chk("rstwait_no_flush", 32'(bus.flush_o),       32'd0);
        end

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), $urandom);
            reset = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
